// File: rtl/stream_rr_sel.sv
// Round-robin, burst-locked grant selector driving slv_sel of an N:1 AXIS mux.
// Optional beat statistics (beat_cnt output, stats_clr input) under `STREAM_RR_SEL_STATS_EN.
module stream_rr_sel #(
    parameter int SlaveNum = 3,
    parameter int MaxBurst = 16,
    parameter int IdleMax  = 2,
    localparam int SelW    = $clog2(SlaveNum)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SlaveNum-1:0] slv_valid,
    input  logic [SlaveNum-1:0] slv_ready,
    output logic [SelW-1:0]     slv_sel,
    output logic                grant_active,
    output logic [SlaveNum-1:0] grant_onehot
`ifdef STREAM_RR_SEL_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [31:0]         beat_cnt
`endif
);

    localparam int BurstW = $clog2(MaxBurst + 1);
    localparam int IdleW  = $clog2(IdleMax + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    if (SlaveNum < 2) begin : g_chk_slavenum
        $error("stream_rr_sel: SlaveNum must be >= 2");
    end
    if (MaxBurst < 1) begin : g_chk_maxburst
        $error("stream_rr_sel: MaxBurst must be >= 1");
    end
    if (IdleMax < 1) begin : g_chk_idlemax
        $error("stream_rr_sel: IdleMax must be >= 1");
    end

    // First requester after p, wrapping so that p itself is considered last.
    function automatic logic [SelW-1:0] rr_pick(input logic [SlaveNum-1:0] req,
                                                input logic [SelW-1:0]     p);
        logic [SelW-1:0] res;
        logic            found;
        int              idx;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= SlaveNum; k++) begin
            idx = (int'(p) + k) % SlaveNum;
            if (!found && req[idx]) begin
                res   = SelW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SelW-1:0]     r_sel, w_sel_nxt;
    logic [SelW-1:0]     r_last, w_last_nxt;
    logic [BurstW-1:0]   r_burst_cnt, w_burst_nxt;
    logic [IdleW-1:0]    r_idle_cnt, w_idle_nxt;
    logic                r_grant_active, w_active_nxt;
    logic [SlaveNum-1:0] r_grant_onehot, w_onehot_nxt;
    logic                w_gnt_valid;
    logic                w_beat;
    logic [SelW-1:0]     w_pick_last;
    logic [SelW-1:0]     w_pick_sel;

    assign w_gnt_valid = slv_valid[r_sel];
    assign w_beat      = w_gnt_valid & slv_ready[r_sel] & r_grant_active;
    assign w_pick_last = rr_pick(slv_valid, r_last);
    assign w_pick_sel  = rr_pick(slv_valid, r_sel);

    // Next-state and next-output decode for the grant FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_burst_nxt = r_burst_cnt;
        w_idle_nxt  = r_idle_cnt;
        case (r_state)
            ST_IDLE: begin
                if (|slv_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_pick_last;
                    w_last_nxt  = w_pick_last;
                    w_burst_nxt = {BurstW{1'b0}};
                    w_idle_nxt  = {IdleW{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (w_beat) begin
                    w_idle_nxt = {IdleW{1'b0}};
                    // Burst end re-arbitrates in the same edge, so there is no bubble.
                    if (r_burst_cnt >= BurstW'(MaxBurst - 1)) begin
                        w_sel_nxt   = w_pick_sel;
                        w_last_nxt  = w_pick_sel;
                        w_burst_nxt = {BurstW{1'b0}};
                    end else begin
                        w_burst_nxt = r_burst_cnt + BurstW'(1);
                    end
                end else if (w_gnt_valid) begin
                    w_idle_nxt = {IdleW{1'b0}};
                end else if (r_idle_cnt >= IdleW'(IdleMax - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_idle_nxt  = {IdleW{1'b0}};
                end else begin
                    w_idle_nxt = r_idle_cnt + IdleW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_active_nxt = (w_state_nxt == ST_GRANT);
        if (w_active_nxt) begin
            w_onehot_nxt = {{(SlaveNum-1){1'b0}}, 1'b1} << w_sel_nxt;
        end else begin
            w_onehot_nxt = {SlaveNum{1'b0}};
        end
    end

    // State, select and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_sel          <= {SelW{1'b0}};
            r_last         <= SelW'(SlaveNum - 1);
            r_burst_cnt    <= {BurstW{1'b0}};
            r_idle_cnt     <= {IdleW{1'b0}};
            r_grant_active <= 1'b0;
            r_grant_onehot <= {SlaveNum{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_sel          <= w_sel_nxt;
            r_last         <= w_last_nxt;
            r_burst_cnt    <= w_burst_nxt;
            r_idle_cnt     <= w_idle_nxt;
            r_grant_active <= w_active_nxt;
            r_grant_onehot <= w_onehot_nxt;
        end
    end

    assign slv_sel      = r_sel;
    assign grant_active = r_grant_active;
    assign grant_onehot = r_grant_onehot;

`ifdef STREAM_RR_SEL_STATS_EN
    logic [31:0] r_beat_cnt;

    // Free-running beat counter; clear wins over a same-cycle beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat_cnt <= 32'd0;
        end else if (stats_clr) begin
            r_beat_cnt <= 32'd0;
        end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end else begin
            r_beat_cnt <= r_beat_cnt;
        end
    end

    assign beat_cnt = r_beat_cnt;
`endif

endmodule
